// File: rtl/wb_regfile.sv
// Write-back select and 32 x DATA_W integer register file with a committed-write counter.
// Optional WB_BYPASS_EN macro makes the read ports return a same-cycle pending commit.
module wb_regfile #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MEM_WB_RegWrite,
    input  logic              MEM_WB_MemToReg,
    input  logic [DATA_W-1:0] MEM_WB_ReadData,
    input  logic [DATA_W-1:0] MEM_WB_ALU_Result,
    input  logic [4:0]        MEM_WB_RD,
    input  logic [4:0]        IF_ID_RS1,
    input  logic [4:0]        IF_ID_RS2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] WB_WriteData,
    output logic [CNT_W-1:0]  WB_Count
);

    logic [DATA_W-1:0] regs_q [32];
    logic [CNT_W-1:0]  count_q;
    logic              commit;

    assign WB_WriteData = MEM_WB_MemToReg ? MEM_WB_ReadData : MEM_WB_ALU_Result;

    // Gated on reset so the bypass path can never leak a write while reset is held.
    assign commit = reset && MEM_WB_RegWrite && (MEM_WB_RD != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else if (commit) begin
            regs_q[MEM_WB_RD] <= WB_WriteData;
            count_q           <= count_q + CNT_W'(1);
        end
    end

    assign WB_Count = count_q;

    always_comb begin
        ReadData1 = '0;
        if (reset && (IF_ID_RS1 != 5'd0)) begin
            ReadData1 = regs_q[IF_ID_RS1];
`ifdef WB_BYPASS_EN
            if (commit && (MEM_WB_RD == IF_ID_RS1)) begin
                ReadData1 = WB_WriteData;
            end
`endif
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (reset && (IF_ID_RS2 != 5'd0)) begin
            ReadData2 = regs_q[IF_ID_RS2];
`ifdef WB_BYPASS_EN
            if (commit && (MEM_WB_RD == IF_ID_RS2)) begin
                ReadData2 = WB_WriteData;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; a second instance with CNT_W = 4 covers counter wrap.
module tb_wb_regfile;

    localparam int unsigned DATA_W = 64;

    logic              clk;
    logic              reset;
    logic              regwrite;
    logic              memtoreg;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] wbd;
    logic [31:0]       cnt;
    logic [DATA_W-1:0] rd1_4;
    logic [DATA_W-1:0] rd2_4;
    logic [DATA_W-1:0] wbd_4;
    logic [3:0]        cnt4;

    int errors = 0;
    int checks = 0;

    wb_regfile #(.DATA_W(DATA_W), .CNT_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .MEM_WB_RegWrite  (regwrite),
        .MEM_WB_MemToReg  (memtoreg),
        .MEM_WB_ReadData  (rdata),
        .MEM_WB_ALU_Result(alu),
        .MEM_WB_RD        (rd),
        .IF_ID_RS1        (rs1),
        .IF_ID_RS2        (rs2),
        .ReadData1        (rd1),
        .ReadData2        (rd2),
        .WB_WriteData     (wbd),
        .WB_Count         (cnt)
    );

    wb_regfile #(.DATA_W(DATA_W), .CNT_W(4)) dut4 (
        .clk              (clk),
        .reset            (reset),
        .MEM_WB_RegWrite  (regwrite),
        .MEM_WB_MemToReg  (memtoreg),
        .MEM_WB_ReadData  (rdata),
        .MEM_WB_ALU_Result(alu),
        .MEM_WB_RD        (rd),
        .IF_ID_RS1        (rs1),
        .IF_ID_RS2        (rs2),
        .ReadData1        (rd1_4),
        .ReadData2        (rd2_4),
        .WB_WriteData     (wbd_4),
        .WB_Count         (cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return 1 time unit after a rising edge; inputs change here, checks follow #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] exp_wbd;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            regwrite = 1'b1;
            memtoreg = 1'($urandom_range(0, 1));
            rdata    = {$urandom, $urandom};
            alu      = {$urandom, $urandom};
            rd       = 5'($urandom_range(1, 31));
            rs1      = rd;
            rs2      = 5'($urandom_range(0, 31));
            exp_wbd  = memtoreg ? rdata : alu;
            #1;
            checks++;
            if (rd1 !== '0) begin
                errors++;
                $display("FAIL reset_rd1 iter %0d: got %h want 0", i, rd1);
            end
            checks++;
            if (rd2 !== '0) begin
                errors++;
                $display("FAIL reset_rd2 iter %0d: got %h want 0", i, rd2);
            end
            checks++;
            if (cnt !== 32'd0 || cnt4 !== 4'd0) begin
                errors++;
                $display("FAIL reset_count iter %0d: got %0d/%0d want 0/0", i, cnt, cnt4);
            end
            checks++;
            if (wbd !== exp_wbd) begin
                errors++;
                $display("FAIL reset_wbmux iter %0d: got %h want %h", i, wbd, exp_wbd);
            end
        end
        regwrite = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_x0();
        tick();
        regwrite = 1'b1;
        memtoreg = 1'b0;
        alu      = 64'hDEAD;
        rdata    = 64'h0;
        rd       = 5'd0;
        rs1      = 5'd0;
        rs2      = 5'd0;
        #1;
        checks++;
        if (wbd !== 64'hDEAD) begin
            errors++;
            $display("FAIL x0_wbmux: got %h want dead", wbd);
        end
        tick();
        regwrite = 1'b0;
        #1;
        checks++;
        if (rd1 !== '0) begin
            errors++;
            $display("FAIL x0_read: got %h want 0", rd1);
        end
        checks++;
        if (cnt !== 32'd0) begin
            errors++;
            $display("FAIL x0_count: got %0d want 0", cnt);
        end
    endtask

    task automatic test_select();
        tick();
        regwrite = 1'b1;
        memtoreg = 1'b1;
        rdata    = 64'h11;
        alu      = 64'h22;
        rd       = 5'd5;
        rs1      = 5'd5;
        rs2      = 5'd0;
        tick();
        regwrite = 1'b0;
        #1;
        checks++;
        if (rd1 !== 64'h11) begin
            errors++;
            $display("FAIL select_mem: got %h want 11", rd1);
        end
        checks++;
        if (cnt !== 32'd1) begin
            errors++;
            $display("FAIL select_count1: got %0d want 1", cnt);
        end
        regwrite = 1'b1;
        memtoreg = 1'b0;
        tick();
        regwrite = 1'b0;
        rs2      = 5'd5;
        #1;
        checks++;
        if (rd1 !== 64'h22 || rd2 !== 64'h22) begin
            errors++;
            $display("FAIL select_alu: got %h/%h want 22/22", rd1, rd2);
        end
        checks++;
        if (cnt !== 32'd2) begin
            errors++;
            $display("FAIL select_count2: got %0d want 2", cnt);
        end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] exp_pre;
`ifdef WB_BYPASS_EN
        exp_pre = 64'hABCD;
`else
        exp_pre = 64'h0;
`endif
        tick();
        regwrite = 1'b1;
        memtoreg = 1'b0;
        alu      = 64'hABCD;
        rdata    = 64'h5A5A;
        rd       = 5'd7;
        rs1      = 5'd7;
        rs2      = 5'd7;
        #1;
        checks++;
        if (rd1 !== exp_pre || rd2 !== exp_pre) begin
            errors++;
            $display("FAIL bypass_pre: got %h/%h want %h", rd1, rd2, exp_pre);
        end
        tick();
        regwrite = 1'b0;
        #1;
        checks++;
        if (rd1 !== 64'hABCD || rd2 !== 64'hABCD) begin
            errors++;
            $display("FAIL bypass_post: got %h/%h want abcd", rd1, rd2);
        end
        checks++;
        if (cnt !== 32'd3) begin
            errors++;
            $display("FAIL bypass_count: got %0d want 3", cnt);
        end
    endtask

    task automatic test_regwrite_gate();
        tick();
        regwrite = 1'b0;
        memtoreg = 1'b0;
        alu      = 64'h55;
        rd       = 5'd9;
        rs1      = 5'd9;
        rs2      = 5'd5;
        tick();
        rd = 5'd5;
        tick();
        #1;
        checks++;
        if (rd1 !== 64'h0) begin
            errors++;
            $display("FAIL gate_x9: got %h want 0", rd1);
        end
        checks++;
        if (rd2 !== 64'h22) begin
            errors++;
            $display("FAIL gate_x5: got %h want 22", rd2);
        end
        checks++;
        if (cnt !== 32'd3) begin
            errors++;
            $display("FAIL gate_count: got %0d want 3", cnt);
        end
    endtask

    task automatic test_async_reset();
        tick();
        regwrite = 1'b1;
        memtoreg = 1'b0;
        alu      = 64'h77;
        rd       = 5'd3;
        rs1      = 5'd3;
        rs2      = 5'd3;
        tick();
        alu = 64'h99;
        #1;
        checks++;
        if (cnt !== 32'd4) begin
            errors++;
            $display("FAIL async_precount: got %0d want 4", cnt);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (rd1 !== '0 || rd2 !== '0) begin
            errors++;
            $display("FAIL async_read: got %h/%h want 0", rd1, rd2);
        end
        checks++;
        if (cnt !== 32'd0) begin
            errors++;
            $display("FAIL async_count: got %0d want 0", cnt);
        end
        tick();
        #1;
        checks++;
        if (rd1 !== '0 || cnt !== 32'd0) begin
            errors++;
            $display("FAIL async_held: got %h cnt %0d want 0 cnt 0", rd1, cnt);
        end
        regwrite = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (rd1 !== '0 || cnt !== 32'd0) begin
            errors++;
            $display("FAIL async_lost_write: got %h cnt %0d want 0 cnt 0", rd1, cnt);
        end
    endtask

    task automatic test_back_to_back_wrap();
        tick();
        memtoreg = 1'b0;
        rd       = 5'd1;
        rs1      = 5'd1;
        rs2      = 5'd3;
        regwrite = 1'b1;
        for (int i = 0; i < 17; i++) begin
            alu = 64'(i + 1);
            tick();
            if (i == 15) begin
                #1;
                checks++;
                if (cnt4 !== 4'd0 || cnt !== 32'd16) begin
                    errors++;
                    $display("FAIL wrap_16: got %0d/%0d want 0/16", cnt4, cnt);
                end
            end
        end
        regwrite = 1'b0;
        #1;
        checks++;
        if (cnt4 !== 4'd1) begin
            errors++;
            $display("FAIL wrap_17: got %0d want 1", cnt4);
        end
        checks++;
        if (cnt !== 32'd17) begin
            errors++;
            $display("FAIL count_17: got %0d want 17", cnt);
        end
        checks++;
        if (rd1 !== 64'd17 || rd1_4 !== 64'd17) begin
            errors++;
            $display("FAIL b2b_last: got %h/%h want 11", rd1, rd1_4);
        end
    endtask

    initial begin
        reset    = 1'b1;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        rdata    = '0;
        alu      = '0;
        rd       = 5'd0;
        rs1      = 5'd0;
        rs2      = 5'd0;
        test_reset();
        test_x0();
        test_select();
        test_bypass();
        test_regwrite_gate();
        test_async_reset();
        test_back_to_back_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
